// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel output stage.
package vga_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    FADE_OUT = 2'd2
  } fade_state_e;

  localparam int CW_DEF = 4;
  localparam int FB_DEF = 4;
  localparam logic SYNC_IDLE = 1'b1;

  // channel index within the packed colour word; multiply by CW for the bit offset
  localparam int R_IDX = 2;
  localparam int G_IDX = 1;
  localparam int B_IDX = 0;
endpackage

// File: rtl/vga_pixel_out_if.sv
// Pixel, sync and fade-control bundle between the pixel generator and output stage.
interface vga_pixel_out_if
  import vga_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int FB = FB_DEF
);
    logic [3*CW-1:0] colour;
    logic            colour_enable;
    logic            hsync_in;
    logic            vsync_in;
    logic            fade_start;
    logic            fade_dir;
    logic [CW-1:0]   vga_r;
    logic [CW-1:0]   vga_g;
    logic [CW-1:0]   vga_b;
    logic            vga_hs;
    logic            vga_vs;
    logic            fade_busy;
    logic            fade_done;
    logic [FB-1:0]   level;

    modport master (
        output colour, colour_enable, hsync_in, vsync_in,
        output fade_start, fade_dir,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs,
        input  fade_busy, fade_done, level
    );

    modport slave (
        input  colour, colour_enable, hsync_in, vsync_in,
        input  fade_start, fade_dir,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs,
        output fade_busy, fade_done, level
    );
endinterface

// File: rtl/vga_channel_scale.sv
// One colour channel scaled by brightness level and registered (pipeline S2).
module vga_channel_scale #(
    parameter int CW = 4,
    parameter int FB = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [CW-1:0] c_i,
    input  logic [FB-1:0] level_i,
    output logic [CW-1:0] q_o
);
    localparam logic [FB-1:0] LMAX = '1;

    logic [CW+FB-1:0] prod;
    logic [CW-1:0]    q_d;
    logic [CW-1:0]    q_q;

    assign prod = (CW+FB)'(c_i) * (CW+FB)'(level_i);

    // full brightness bypasses the multiply so the colour passes unchanged
    always_comb begin
        q_d = CW'(prod >> FB);
        if (level_i == LMAX) q_d = c_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn) q_q <= '0;
        else         q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/vga_pixel_out.sv
// VGA output stage: two-stage colour/sync pipeline with a frame-stepped fade engine.
module vga_pixel_out
  import vga_pkg::*;
#(
    parameter int CW          = CW_DEF,
    parameter int FB          = FB_DEF,
    parameter int STEP_FRAMES = 2
) (
    input  logic           clk,
    input  logic           resetn,
    vga_pixel_out_if.slave bus
);
    localparam logic [1:0]    S_IDLE = 2'(IDLE);
    localparam logic [1:0]    S_IN   = 2'(FADE_IN);
    localparam logic [1:0]    S_OUT  = 2'(FADE_OUT);
    localparam logic [FB-1:0] LMAX   = '1;
    localparam int            CNTW   = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STEP_FRAMES - 1);

    logic [3*CW-1:0] col_q;
    logic            hs1_q, vs1_q, hs2_q, vs2_q;
    logic            vs_prev_q;
    logic            tick;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [FB-1:0]   level_q, level_d;
    logic            done_q, done_d;
    logic [FB-1:0]   step_lvl;
    logic [FB-1:0]   target;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q     <= '0;
            hs1_q     <= SYNC_IDLE;
            vs1_q     <= SYNC_IDLE;
            hs2_q     <= SYNC_IDLE;
            vs2_q     <= SYNC_IDLE;
            vs_prev_q <= SYNC_IDLE;
        end else begin
            col_q     <= bus.colour_enable ? bus.colour : '0;
            hs1_q     <= bus.hsync_in;
            vs1_q     <= bus.vsync_in;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            vs_prev_q <= bus.vsync_in;
        end
    end

    assign tick = vs_prev_q & ~bus.vsync_in;

    vga_channel_scale #(.CW(CW), .FB(FB)) u_r (
        .clk(clk), .resetn(resetn),
        .c_i(col_q[R_IDX*CW +: CW]), .level_i(level_q), .q_o(bus.vga_r)
    );
    vga_channel_scale #(.CW(CW), .FB(FB)) u_g (
        .clk(clk), .resetn(resetn),
        .c_i(col_q[G_IDX*CW +: CW]), .level_i(level_q), .q_o(bus.vga_g)
    );
    vga_channel_scale #(.CW(CW), .FB(FB)) u_b (
        .clk(clk), .resetn(resetn),
        .c_i(col_q[B_IDX*CW +: CW]), .level_i(level_q), .q_o(bus.vga_b)
    );

    assign step_lvl = (state_q == S_IN) ? level_q + 1'b1 : level_q - 1'b1;
    assign target   = (state_q == S_IN) ? LMAX : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.fade_start) begin
                    if (bus.fade_dir ? (level_q == LMAX) : (level_q == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = bus.fade_dir ? S_IN : S_OUT;
                        cnt_d   = '0;
                    end
                end
            end
            S_IN, S_OUT: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        level_d = step_lvl;
                        if (step_lvl == target) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            level_q <= LMAX;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            done_q  <= done_d;
        end
    end

    assign bus.vga_hs    = hs2_q;
    assign bus.vga_vs    = vs2_q;
    assign bus.fade_busy = (state_q != S_IDLE);
    assign bus.fade_done = done_q;
    assign bus.level     = level_q;
endmodule

// File: doc/vga_pixel_out.md
# vga_pixel_out

Parametrised VGA pixel output stage between the pixel generator and the DAC pins. It replaces the fixed 4-bit-per-channel colour register with configurable channel width, a two-stage pipeline with matched hsync/vsync delay, and a frame-stepped brightness fade engine with a start/busy/done handshake. Blanking outside the active area is preserved: outputs are forced to zero whenever `colour_enable` is low.

## Interface

- `CW`, 4, bits per colour channel (≥1)
- `FB`, 4, brightness level bits; levels 0..LMAX, LMAX = 2^FB−1
- `STEP_FRAMES`, 2, frame ticks per brightness step (≥1)

- `clk` in 1 pixel clock
- `resetn` in 1 one clock; reset is synchronous and active-low
- `colour` in 3*CW packed {R[3CW−1:2CW], G[2CW−1:CW], B[CW−1:0]}
- `colour_enable` in 1 active-area qualifier
- `hsync_in`, `vsync_in` in 1 each, active-low syncs from timing generator
- `fade_start` in 1 single-cycle request pulse
- `fade_dir` in 1 sampled with `fade_start`: 1 = fade in (toward LMAX), 0 = fade out (toward 0)
- `vga_r`, `vga_g`, `vga_b` out CW each, registered
- `vga_hs`, `vga_vs` out 1 each, registered, delayed syncs
- `fade_busy` out 1 high while a fade is in progress
- `fade_done` out 1 single-cycle pulse when fade completes
- `level` out FB current brightness level

## Operation

- Pipeline S1: register `colour` (zeroed if `colour_enable`=0), `colour_enable`, syncs. S2: scale and register to outputs.
- Scaling per channel: level==LMAX → out = c exactly; otherwise out = (c*level) >> FB, with a CW+FB-bit product truncated to CW bits. level 0 → 0.
- Frame tick: internal, one cycle, asserted on `vsync_in` 1→0 (previous-sample register).
- FSM states IDLE, FADE_IN, FADE_OUT.
  - IDLE + `fade_start`: if dir=1 and level==LMAX, or dir=0 and level==0, pulse `fade_done` next cycle and stay IDLE; otherwise go to FADE_IN/FADE_OUT, clear frame counter.
  - FADE_*: on each frame tick, frame counter increments; when it reaches STEP_FRAMES−1 it clears, and level ±1. When level reaches its target (LMAX/0), return to IDLE and pulse `fade_done` that cycle.
  - `fade_start` while not IDLE: ignored.
- `fade_busy` = state≠IDLE.
- `level` changes only on frame ticks, so brightness is constant within a frame.

## Timing

- Reset (`resetn`=0 at clk edge): `vga_r/g/b`=0, `vga_hs`=`vga_vs`=1, pipeline regs cleared (syncs to 1), state IDLE, frame counter 0, `level`=LMAX, `fade_busy`=0, `fade_done`=0. Reset mid-fade aborts it without `fade_done`.
- Latency: `colour`/`colour_enable`/syncs at edge N → outputs at edge N+2; colour and sync always aligned.
- Level used in S2 is sampled at the S2 edge; a level change takes effect on the pixel in S2 at that edge.
- `fade_start` sampled at edge N → `fade_busy` high from N+1 (or `fade_done` at N+1 for the no-op case).
- Full fade from 0 to LMAX takes LMAX*STEP_FRAMES frame ticks; `fade_done` coincides with the edge on which `level` reaches its target.
- A frame tick coinciding with `fade_start` in IDLE is not counted.

## Structure

- Shared package `vga_pkg`: state enum (IDLE, FADE_IN, FADE_OUT), default CW/FB, sync inactive level constant, RGB field offsets.
- Sub-module `vga_channel_scale` (params CW, FB): registered per-channel scale, instantiated three times.
- FSM, frame counter, and sync delay are in the top level.

## Test plan

- Reset then colour=12'hF84, enable=1, CW=4: outputs R=F, G=8, B=4 two cycles after input; hs/vs delayed by 2.
- enable=0 with colour=12'hFFF → outputs 0 at N+2; syncs still pass.
- fade_start, dir=0 from LMAX=15, STEP_FRAMES=2: level decrements every 2nd vsync falling edge; after 30 ticks level=0, `fade_done` pulse, colour F → 0; at level 8, F → 7.
- fade_start, dir=1 at level 15 → `fade_done` next cycle, `fade_busy` never high.
- `fade_start` during fade-out at level 9 is ignored; resetn low at level 5 → level=15, busy=0, no done pulse.
- Sync-only check: vsync toggles every 10 cycles during fade-in from 0; level steps exactly at the falling edges, never mid-frame.
